// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder/multiplier later).
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_subtractor_pkg;

  // Control-FSM encodings kept stable so sibling serial blocks decode the same way.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when the bits
  // match and a borrow arrives from below.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock, plus final borrow.
// Latency: start sampled at edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, and a new start is accepted in IDLE or DONE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             bo_bit;
  logic             load;
  logic             last_bit;

  // The single datapath bit slice; the shift registers feed it their LSBs.
  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bo_bit)
  );

  // A launch is accepted from IDLE or straight out of DONE (back-to-back).
  assign load     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle unless a new start chains another run.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load operands on launch, then retire one result bit per RUN cycle.
  // diff is not cleared on load; WIDTH shifts overwrite every bit before done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      diff   <= {d_bit, diff[WIDTH-1:1]};
      borrow <= bo_bit;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        bout <= bo_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Call at a negedge: presents operands with start for exactly one rising edge.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles from the load edge until done is seen at a negedge (lat=-1 on timeout).
  // Optionally pulses start with a=AA at the negedge where lat==inj_at.
  task automatic wait_done(input int inj_at, output int lat, output int busy_cyc);
    bit seen;
    seen     = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) busy_cyc++;
        if (lat == inj_at) begin
          a     = 8'hAA;
          b     = 8'h00;
          start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    start_op(8'h05, 8'h03);
    wait_done(-1, lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    checks++; if (diff !== 8'h02) begin failures++; $display("FAIL basic_diff got=%h exp=02", diff); end
    checks++; if (bout !== 1'b0) begin failures++; $display("FAIL basic_bout got=%b exp=0", bout); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_done_width got done=%b busy=%b exp=0 0", done, busy); end
    checks++; if (diff !== 8'h02) begin failures++; $display("FAIL basic_diff_hold got=%h exp=02", diff); end
  endtask

  task automatic test_borrow();
    int lat, bc;
    start_op(8'h03, 8'h05);
    wait_done(-1, lat, bc);
    checks++; if ({bout, diff} !== 9'h1FE) begin failures++; $display("FAIL borrow_3_5 got=%b_%h exp=1_fe", bout, diff); end
    @(negedge clk);
    start_op(8'h00, 8'h00);
    wait_done(-1, lat, bc);
    checks++; if ({bout, diff} !== 9'h000) begin failures++; $display("FAIL zero_0_0 got=%b_%h exp=0_00", bout, diff); end
    @(negedge clk);
  endtask

  task automatic test_ripple();
    int lat, bc;
    start_op(8'h80, 8'h7F);
    wait_done(-1, lat, bc);
    checks++; if ({bout, diff} !== 9'h001) begin failures++; $display("FAIL ripple_80_7f got=%b_%h exp=0_01", bout, diff); end
    @(negedge clk);
    start_op(8'hFF, 8'hFF);
    wait_done(-1, lat, bc);
    checks++; if ({bout, diff} !== 9'h000) begin failures++; $display("FAIL equal_ff_ff got=%b_%h exp=0_00", bout, diff); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int lat, bc;
    start_op(8'h37, 8'h12);
    wait_done(2, lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL ignore_busy_cycles got=%0d exp=8", bc); end
    checks++; if ({bout, diff} !== 9'h025) begin failures++; $display("FAIL ignore_result got=%b_%h exp=0_25", bout, diff); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ignore_done_width got done=%b busy=%b exp=0 0", done, busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc;
    start_op(8'hF0, 8'hF1);
    repeat (3) begin
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, bout, diff} !== 11'h000) begin failures++; $display("FAIL midreset_async got busy=%b done=%b bout=%b diff=%h exp all 0", busy, done, bout, diff); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_idle got busy=%b done=%b exp=0 0", busy, done); end
    start_op(8'h10, 8'h01);
    wait_done(-1, lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL midreset_latency got=%0d exp=8", lat); end
    checks++; if ({bout, diff} !== 9'h00F) begin failures++; $display("FAIL midreset_result got=%b_%h exp=0_0f", bout, diff); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int          lat, bc;
    logic [7:0]  av, bv, exp_d;
    logic        exp_b;
    bit          b2b;
    b2b = 1'b0;
    for (int n = 0; n < 256; n++) begin
      av    = 8'($urandom);
      bv    = 8'($urandom);
      exp_d = av - bv;
      exp_b = (av < bv);
      if (!b2b) begin
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rand_done_width n=%0d got=%b exp=0", n, done); end
      end
      start_op(av, bv);
      wait_done(-1, lat, bc);
      checks++; if (lat !== 8) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=8", n, lat); end
      checks++; if ({bout, diff} !== {exp_b, exp_d}) begin
        failures++;
        $display("FAIL rand_result n=%0d a=%h b=%h got=%b_%h exp=%b_%h", n, av, bv, bout, diff, exp_b, exp_d);
      end
      if (lat < 0) break;
      b2b = ($urandom_range(1, 0) == 1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ripple();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
